// File: rtl/add_order_mpid_packer.sv
// Packs one Add Order (with MPID) message into a 64-bit byte-keyed word stream,
// starting at a byte offset inside the first word and reporting where it ended.
module add_order_mpid_packer #(
    parameter logic [7:0] MSG_TYPE = 8'h46
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  trackerIn,
    input  logic [31:0] timeStamp,
    input  logic [63:0] orderID,
    input  logic [31:0] orderBookID,
    input  logic [7:0]  side,
    input  logic [31:0] orderBookPosition,
    input  logic [63:0] quantity,
    input  logic [31:0] price,
    input  logic [15:0] orderAttributes,
    input  logic [7:0]  lotType,
    input  logic [55:0] participantID,
    output logic [63:0] dataOut,
    output logic [7:0]  keepOut,
    output logic        outValid,
    input  logic        outReady,
    output logic        lastOut,
    output logic        busy,
    output logic [5:0]  trackerOut
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t       state, stateNext;
    logic [351:0] msg;
    logic [5:0]   tOff;
    logic [2:0]   wordIdx;
    logic [447:0] stream;
    logic [55:0]  byteMask;
    logic [2:0]   lastIdx;
    logic         isLast;
    logic         xfer;
    logic         unusedTrk;

    // Offsets are byte-granular; the low bits of trackerIn carry no meaning here.
    assign unusedTrk = ^trackerIn[2:0];

    // 44 message bytes shifted into a 7-word window; word/keep are sliced from it.
    assign stream   = {96'd0, msg} << tOff;
    assign byteMask = {12'd0, {44{1'b1}}} << tOff[5:3];
    assign lastIdx  = (tOff > 6'd32) ? 3'd6 : 3'd5;
    assign isLast   = (wordIdx == lastIdx);
    assign xfer     = (state == SEND) && outReady;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = SEND;
            SEND:    if (xfer && isLast) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg        <= '0;
            tOff       <= '0;
            wordIdx    <= '0;
            trackerOut <= '0;
        end else if (state == IDLE && start) begin
            msg     <= {participantID, lotType, orderAttributes, price, quantity,
                        orderBookPosition, side, orderBookID, orderID, timeStamp, MSG_TYPE};
            tOff    <= {trackerIn[5:3], 3'b000};
            wordIdx <= '0;
        end else if (xfer) begin
            // 352 mod 64 == 32, so the end offset is just T+32 wrapped to 6 bits.
            if (isLast) trackerOut <= tOff + 6'd32;
            else        wordIdx    <= wordIdx + 3'd1;
        end
    end

    assign busy     = (state == SEND);
    assign outValid = busy;
    assign lastOut  = busy && isLast;
    assign dataOut  = busy ? stream[{wordIdx, 6'd0} +: 64] : 64'd0;
    assign keepOut  = busy ? byteMask[{wordIdx, 3'd0} +: 8] : 8'd0;

endmodule

// File: tb/tb_add_order_mpid_packer.sv
// Directed scoreboard bench for add_order_mpid_packer: byte-level reference model,
// stall-stability monitor, busy-start/final-start rejection and mid-message reset.
module tb_add_order_mpid_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        outReady = 1'b0;
    logic [5:0]  trackerIn = '0;
    logic [31:0] timeStamp = '0;
    logic [63:0] orderID = '0;
    logic [31:0] orderBookID = '0;
    logic [7:0]  side = '0;
    logic [31:0] orderBookPosition = '0;
    logic [63:0] quantity = '0;
    logic [31:0] price = '0;
    logic [15:0] orderAttributes = '0;
    logic [7:0]  lotType = '0;
    logic [55:0] participantID = '0;
    logic [63:0] dataOut;
    logic [7:0]  keepOut;
    logic        outValid, lastOut, busy;
    logic [5:0]  trackerOut;

    add_order_mpid_packer dut (
        .clk(clk), .rst(rst), .start(start), .trackerIn(trackerIn),
        .timeStamp(timeStamp), .orderID(orderID), .orderBookID(orderBookID),
        .side(side), .orderBookPosition(orderBookPosition), .quantity(quantity),
        .price(price), .orderAttributes(orderAttributes), .lotType(lotType),
        .participantID(participantID), .dataOut(dataOut), .keepOut(keepOut),
        .outValid(outValid), .outReady(outReady), .lastOut(lastOut),
        .busy(busy), .trackerOut(trackerOut)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t       sb[$];
    int          nCmp = 0;
    int          nErr = 0;
    int          beatCnt = 0;
    logic [63:0] firstData, holdD;
    logic [7:0]  firstKeep, lastKeep, holdK;
    logic        holdL;
    logic        stallPrev = 1'b0;
    logic        toggleRdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: a beat is taken on the edge following a negedge with valid&ready.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) stallPrev = 1'b0;
        else begin
            if (stallPrev) begin
                chk("stallData", dataOut, holdD);
                chk("stallKeep", {56'd0, keepOut}, {56'd0, holdK});
                chk("stallLast", {63'd0, lastOut}, {63'd0, holdL});
            end
            stallPrev = outValid && !outReady;
            holdD = dataOut; holdK = keepOut; holdL = lastOut;
            if (outValid && outReady) begin
                if (sb.size() == 0) chk("unexpectedBeat", 64'd1, 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("data", dataOut, e.d);
                    chk("keep", {56'd0, keepOut}, {56'd0, e.k});
                    chk("last", {63'd0, lastOut}, {63'd0, e.l});
                end
                if (beatCnt == 0) begin firstData = dataOut; firstKeep = keepOut; end
                lastKeep = keepOut;
                beatCnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
        if (toggleRdy) outReady = ~outReady;
    endtask

    task automatic randFields();
        logic [63:0] t64;
        timeStamp = $urandom(); orderID = {$urandom(), $urandom()};
        orderBookID = $urandom(); side = 8'($urandom());
        orderBookPosition = $urandom(); quantity = {$urandom(), $urandom()};
        price = $urandom(); orderAttributes = 16'($urandom()); lotType = 8'($urandom());
        t64 = {$urandom(), $urandom()}; participantID = t64[55:0];
    endtask

    // Reference: stream byte j is message byte j - T/8 when that lies in 0..43.
    task automatic pushMsg(input int t);
        logic [351:0] m;
        beat_t b;
        int n, by;
        m = {participantID, lotType, orderAttributes, price, quantity,
             orderBookPosition, side, orderBookID, orderID, timeStamp, 8'h46};
        n = (t <= 32) ? 6 : 7;
        for (int w = 0; w < n; w++) begin
            b = '0;
            for (int j = 0; j < 8; j++) begin
                by = w * 8 + j - t / 8;
                if (by >= 0 && by < 44) begin
                    b.d[j*8 +: 8] = m[by*8 +: 8];
                    b.k[j] = 1'b1;
                end
            end
            b.l = (w == n - 1);
            sb.push_back(b);
        end
    endtask

    task automatic startMsg(input logic [5:0] tin);
        randFields();
        trackerIn = tin;
        beatCnt = 0;
        start = 1'b1;
        pushMsg({26'd0, tin[5:3], 3'b000});
        step();
        start = 1'b0;
        chk("latency1Valid", {63'd0, outValid}, 64'd1);
        chk("busyInSend", {63'd0, busy}, 64'd1);
    endtask

    task automatic waitIdle(input int budget);
        int c = 0;
        while (busy && c < budget) begin step(); c++; end
        chk("idleTimeout", {63'd0, busy}, 64'd0);
        chk("queueDrained", 64'(sb.size()), 64'd0);
        chk("validIdle", {63'd0, outValid}, 64'd0);
    endtask

    task automatic waitBeats(input int nb);
        int c = 0;
        while (beatCnt < nb && c < 50) begin step(); c++; end
        chk("beatTimeout", 64'(beatCnt), 64'(nb));
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rstData", dataOut, 64'd0);
        chk("rstKeep", {56'd0, keepOut}, 64'd0);
        chk("rstValid", {63'd0, outValid}, 64'd0);
        chk("rstBusy", {63'd0, busy}, 64'd0);
        chk("rstLast", {63'd0, lastOut}, 64'd0);
        chk("rstTracker", {58'd0, trackerOut}, 64'd0);
        rst = 1'b1;
        outReady = 1'b1;
        step();

        // T=0, full-rate sink
        startMsg(6'd0);
        waitIdle(40);
        chk("A_beats", 64'(beatCnt), 64'd6);
        chk("A_type", {56'd0, firstData[7:0]}, 64'h46);
        chk("A_lastKeep", {56'd0, lastKeep}, 64'h0F);
        chk("A_tracker", {58'd0, trackerOut}, 64'd32);
        step();

        // T=32 (low bits of trackerIn set to show they are ignored)
        startMsg(6'd35);
        waitIdle(40);
        chk("B_beats", 64'(beatCnt), 64'd6);
        chk("B_firstKeep", {56'd0, firstKeep}, 64'hF0);
        chk("B_type", {56'd0, firstData[39:32]}, 64'h46);
        chk("B_lastKeep", {56'd0, lastKeep}, 64'hFF);
        chk("B_tracker", {58'd0, trackerOut}, 64'd0);
        step();

        // T=40 with outReady toggling every cycle
        toggleRdy = 1'b1;
        startMsg(6'd40);
        waitIdle(60);
        toggleRdy = 1'b0;
        outReady = 1'b1;
        chk("C_beats", 64'(beatCnt), 64'd7);
        chk("C_firstKeep", {56'd0, firstKeep}, 64'hE0);
        chk("C_lastKeep", {56'd0, lastKeep}, 64'h01);
        chk("C_tracker", {58'd0, trackerOut}, 64'd8);
        step();

        // start during word 3 is ignored; fields change too
        startMsg(6'd16);
        waitBeats(3);
        randFields();
        trackerIn = 6'd48;
        start = 1'b1;
        step();
        start = 1'b0;
        waitIdle(40);
        chk("D_beats", 64'(beatCnt), 64'd6);
        chk("D_tracker", {58'd0, trackerOut}, 64'd48);
        repeat (5) begin
            step();
            chk("D_noSecondMsg", {63'd0, outValid}, 64'd0);
        end

        // start coinciding with the final transfer is ignored
        startMsg(6'd24);
        begin
            int c = 0;
            while (!lastOut && c < 40) begin step(); c++; end
        end
        chk("E_reachedLast", {63'd0, lastOut}, 64'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("E_startIgnored", {63'd0, busy}, 64'd0);
        chk("E_tracker", {58'd0, trackerOut}, 64'd56);
        chk("E_queue", 64'(sb.size()), 64'd0);
        step();
        chk("E_stillIdle", {63'd0, outValid}, 64'd0);

        // async reset mid-message during word 2
        startMsg(6'd0);
        waitBeats(2);
        #2 rst = 1'b0;
        #1;
        chk("F_valid", {63'd0, outValid}, 64'd0);
        chk("F_busy", {63'd0, busy}, 64'd0);
        chk("F_last", {63'd0, lastOut}, 64'd0);
        chk("F_data", dataOut, 64'd0);
        chk("F_tracker", {58'd0, trackerOut}, 64'd0);
        sb.delete();
        step();
        rst = 1'b1;
        startMsg(6'd8);
        waitIdle(40);
        chk("F_beats", 64'(beatCnt), 64'd6);
        chk("F_lastKeep", {56'd0, lastKeep}, 64'h1F);
        chk("F_endTracker", {58'd0, trackerOut}, 64'd40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/add_order_mpid_packer.md
ADD_ORDER_MPID_PACKER -- requirements
Module: add_order_mpid_packer

Interface
REQ-001 The block SHALL have parameter MSG_TYPE, default 8'h46, the message-type byte placed first in every message.
REQ-002 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-004 The block SHALL have port start  input  1  request to pack one message; sampled only in IDLE.
REQ-005 The block SHALL have port trackerIn  input  6  bit offset of message start in first output word; bits [2:0] ignored (byte-aligned).
REQ-006 The block SHALL have field inputs timeStamp 32, orderID 64, orderBookID 32, side 8, orderBookPosition 32, quantity 64, price 32, orderAttributes 16, lotType 8, participantID 56, all sampled with start.
REQ-007 The block SHALL have port dataOut  output  64  packed output word.
REQ-008 The block SHALL have port keepOut  output  8  byte-valid mask for dataOut, bit i covers dataOut[8i+7:8i].
REQ-009 The block SHALL have ports outValid output 1 (word present), outReady input 1 (sink accepts), lastOut output 1 (final word of message).
REQ-010 The block SHALL have ports busy output 1 (message in progress) and trackerOut output 6 (bit offset following last message byte).

Function
REQ-011 Message vector M[351:0] SHALL be: MSG_TYPE[7:0], timeStamp[39:8], orderID[103:40], orderBookID[135:104], side[143:136], orderBookPosition[175:144], quantity[239:176], price[271:240], orderAttributes[287:272], lotType[295:288], participantID[351:296].
REQ-012 Output stream SHALL equal M shifted left by T = {trackerIn[5:3],3'b000}, word k being bits [64k+63:64k]; bits below T and above T+351 SHALL be zero.
REQ-013 Word count N SHALL be 6 when T <= 32 and 7 when T > 32.
REQ-014 States SHALL be IDLE and SEND; IDLE->SEND on start in IDLE; SEND->IDLE on transfer of the final word.
REQ-015 start in IDLE SHALL capture all fields and T on that edge; outValid SHALL assert the following cycle (latency 1).
REQ-016 start while busy SHALL be ignored, with no effect on the message in progress or captured fields.
REQ-017 A transfer SHALL occur on a rising edge with outValid=1 and outReady=1; dataOut, keepOut, lastOut SHALL stay stable while outValid=1 and outReady=0.
REQ-018 keepOut SHALL be 0xFF except: first word bits below T/8 cleared; last word bits at and above ((T+352) mod 64)/8 cleared unless that value is 0.
REQ-019 lastOut SHALL be 1 only with the N-th word; busy SHALL equal (state==SEND); outValid SHALL be 0 in IDLE.
REQ-020 trackerOut SHALL update to (T+352) mod 64 on transfer of the final word and otherwise hold.
REQ-021 start coinciding with the final transfer SHALL be ignored; next message requires start in IDLE (one idle cycle minimum between messages).

Reset
REQ-022 rst=0 SHALL immediately force IDLE and dataOut=0, keepOut=0, outValid=0, lastOut=0, busy=0, trackerOut=0, and clear captured fields, including mid-message.
REQ-023 After rst deasserts, the first start SHALL be honoured on the first rising edge at which it is sampled high.

Verification
REQ-024 T=0, all fields distinct patterns, outReady=1 -> 6 consecutive words, word0[7:0]=8'h46, word5 keepOut=0x0F, lastOut on word5, trackerOut=32.
REQ-025 trackerIn=32 -> 6 words, word0 keepOut=0xF0 with word0[39:32]=8'h46, word5 keepOut=0xFF, trackerOut=0.
REQ-026 trackerIn=40 with outReady toggling every cycle -> 7 words, word0 keepOut=0xE0, word6 keepOut=0x01, outputs stable while stalled, trackerOut=8.
REQ-027 start pulsed during word 3 of a message -> ignored; captured fields unchanged; no second message emitted until new start in IDLE.
REQ-028 rst=0 asserted between clock edges during word 2 -> outValid, busy, lastOut drop immediately; after release and start with T=8 -> 6 words, word5 keepOut=0x1F, trackerOut=40.
